// File: rtl/gb_apu_pkg.sv
// Shared APU constants and helpers for the envelope bank and its channel units.
package gb_apu_pkg;

  localparam int ENV_NUM_CH   = 3;
  localparam int ENV_VOL_W    = 4;
  localparam int ENV_PERIOD_W = 3;

  // Full-scale volume for a given width, usable in localparam expressions.
  function automatic int full_scale(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/gb_envelope_channel.sv
// One envelope unit: ramps the volume one step every latched-period ticks until it
// reaches a bound, then freezes there with active cleared.
module gb_envelope_channel
  import gb_apu_pkg::*;
#(
  parameter int VOL_W    = ENV_VOL_W,
  parameter int PERIOD_W = ENV_PERIOD_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_i,
  input  logic                start_i,
  input  logic [VOL_W-1:0]    init_vol_i,
  input  logic                increasing_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic [VOL_W-1:0]    vol_o,
  output logic                active_o
);

  localparam logic [VOL_W-1:0]    VolMax   = VOL_W'(full_scale(VOL_W));
  localparam logic [VOL_W-1:0]    VolOne   = VOL_W'(1);
  localparam logic [PERIOD_W-1:0] TimerOne = PERIOD_W'(1);

  logic [VOL_W-1:0]    vol_q, vol_d;
  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                active_q, active_d;

  // Start overrides a coincident tick; a step at the bound clears active instead of wrapping.
  always_comb begin
    vol_d    = vol_q;
    timer_d  = timer_q;
    period_d = period_q;
    active_d = active_q;
    if (start_i) begin
      vol_d    = init_vol_i;
      period_d = period_i;
      timer_d  = period_i;
      active_d = (period_i != '0);
    end else if (tick_i && active_q) begin
      if (timer_q > TimerOne) begin
        timer_d = timer_q - TimerOne;
      end else if (timer_q == TimerOne) begin
        timer_d = period_q;
        if (increasing_i) begin
          if (vol_q != VolMax) vol_d = vol_q + VolOne;
          else                 active_d = 1'b0;
        end else begin
          if (vol_q != '0) vol_d = vol_q - VolOne;
          else             active_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vol_q    <= '0;
      timer_q  <= '0;
      period_q <= '0;
      active_q <= 1'b0;
    end else begin
      vol_q    <= vol_d;
      timer_q  <= timer_d;
      period_q <= period_d;
      active_q <= active_d;
    end
  end

  assign vol_o    = vol_q;
  assign active_o = active_q;

endmodule

// File: rtl/gb_envelope_bank.sv
// Bank of independent envelope units sharing the frame-sequencer tick; unpacks the
// per-channel register buses and derives the DAC enables.
module gb_envelope_bank
  import gb_apu_pkg::*;
#(
  parameter int NUM_CH   = ENV_NUM_CH,
  parameter int VOL_W    = ENV_VOL_W,
  parameter int PERIOD_W = ENV_PERIOD_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clk_vol_env,
  input  logic [NUM_CH-1:0]          start,
  input  logic [NUM_CH*VOL_W-1:0]    initial_volume,
  input  logic [NUM_CH-1:0]          envelope_increasing,
  input  logic [NUM_CH*PERIOD_W-1:0] num_envelope_sweeps,
  output logic [NUM_CH*VOL_W-1:0]    target_vol,
  output logic [NUM_CH-1:0]          env_active,
  output logic [NUM_CH-1:0]          dac_enabled
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    gb_envelope_channel #(
      .VOL_W   (VOL_W),
      .PERIOD_W(PERIOD_W)
    ) u_channel (
      .clk         (clk),
      .rst         (rst),
      .tick_i      (clk_vol_env),
      .start_i     (start[i]),
      .init_vol_i  (initial_volume[i*VOL_W +: VOL_W]),
      .increasing_i(envelope_increasing[i]),
      .period_i    (num_envelope_sweeps[i*PERIOD_W +: PERIOD_W]),
      .vol_o       (target_vol[i*VOL_W +: VOL_W]),
      .active_o    (env_active[i])
    );

    // The DAC stays powered unless the channel is programmed to decay from silence.
    assign dac_enabled[i] = (initial_volume[i*VOL_W +: VOL_W] != '0) || envelope_increasing[i];
  end

endmodule

// File: tb/tb_gb_envelope_bank.sv
// Self-checking bench for gb_envelope_bank: directed vector table, hand-written ramp,
// and randomized traffic against a tick-counting reference model.
module tb_gb_envelope_bank;

  localparam int NCH = 3;
  localparam int VW  = 4;
  localparam int PW  = 3;
  localparam int VMAX = 15;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                clk_vol_env = 1'b0;
  logic [NCH-1:0]      start = '0;
  logic [NCH*VW-1:0]   initial_volume = '0;
  logic [NCH-1:0]      envelope_increasing = '0;
  logic [NCH*PW-1:0]   num_envelope_sweeps = '0;
  logic [NCH*VW-1:0]   target_vol;
  logic [NCH-1:0]      env_active;
  logic [NCH-1:0]      dac_enabled;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: volume, latched period, ticks seen since the last step, active.
  int mVol[NCH];
  int mPer[NCH];
  int mCnt[NCH];
  bit mAct[NCH];

  typedef struct {
    logic              r;
    logic              t;
    logic [NCH-1:0]    st;
    logic [NCH*VW-1:0] iv;
    logic [NCH-1:0]    inc;
    logic [NCH*PW-1:0] per;
    logic [NCH*VW-1:0] expVol;
    logic [NCH-1:0]    expAct;
    logic [NCH-1:0]    expDac;
  } vec_t;

  vec_t vecs[16];

  gb_envelope_bank dut (
    .clk                (clk),
    .rst                (rst),
    .clk_vol_env        (clk_vol_env),
    .start              (start),
    .initial_volume     (initial_volume),
    .envelope_increasing(envelope_increasing),
    .num_envelope_sweeps(num_envelope_sweeps),
    .target_vol         (target_vol),
    .env_active         (env_active),
    .dac_enabled        (dac_enabled)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NCH*VW-1:0] modelVolBus();
    logic [NCH*VW-1:0] b;
    b = '0;
    for (int c = 0; c < NCH; c++) b[c*VW +: VW] = VW'(mVol[c]);
    return b;
  endfunction

  function automatic logic [NCH-1:0] modelActBus();
    logic [NCH-1:0] b;
    for (int c = 0; c < NCH; c++) b[c] = mAct[c];
    return b;
  endfunction

  task automatic modelUpdate();
    for (int c = 0; c < NCH; c++) begin
      if (rst) begin
        mVol[c] = 0; mPer[c] = 0; mCnt[c] = 0; mAct[c] = 0;
      end else if (start[c]) begin
        mVol[c] = int'(initial_volume[c*VW +: VW]);
        mPer[c] = int'(num_envelope_sweeps[c*PW +: PW]);
        mCnt[c] = 0;
        mAct[c] = (mPer[c] != 0);
      end else if (clk_vol_env && mAct[c]) begin
        mCnt[c]++;
        if (mCnt[c] == mPer[c]) begin
          mCnt[c] = 0;
          if (envelope_increasing[c]) begin
            if (mVol[c] < VMAX) mVol[c]++; else mAct[c] = 0;
          end else begin
            if (mVol[c] > 0) mVol[c]--; else mAct[c] = 0;
          end
        end
      end
    end
  endtask

  task automatic checkOutput();
    checkEq("model target_vol", 32'(target_vol), 32'(modelVolBus()));
    checkEq("model env_active", 32'(env_active), 32'(modelActBus()));
  endtask

  // Drives one cycle of inputs, checks the combinational DAC enables, then the registered state.
  task automatic applyStimulus(input logic r, input logic t, input logic [NCH-1:0] st,
                               input logic [NCH*VW-1:0] iv, input logic [NCH-1:0] inc,
                               input logic [NCH*PW-1:0] per);
    logic [NCH-1:0] expDac;
    rst = r; clk_vol_env = t; start = st;
    initial_volume = iv; envelope_increasing = inc; num_envelope_sweeps = per;
    #2;
    for (int c = 0; c < NCH; c++) expDac[c] = (iv[c*VW +: VW] != 0) || inc[c];
    checkEq("model dac_enabled", 32'(dac_enabled), 32'(expDac));
    @(posedge clk);
    modelUpdate();
    #1;
    checkOutput();
  endtask

  initial begin
    vec_t v;
    logic [NCH*PW-1:0] p1;
    logic [NCH*VW-1:0] expV;
    p1 = 9'b000_011_000;
    vecs[0]  = '{1'b1, 1'b0, 3'b000, 12'h000, 3'b000, 9'b0, 12'h000, 3'b000, 3'b000};
    vecs[1]  = '{1'b0, 1'b0, 3'b010, 12'h030, 3'b010, p1, 12'h030, 3'b010, 3'b010};
    vecs[2]  = '{1'b0, 1'b1, 3'b000, 12'h030, 3'b010, p1, 12'h030, 3'b010, 3'b010};
    vecs[3]  = '{1'b0, 1'b1, 3'b000, 12'h030, 3'b010, p1, 12'h030, 3'b010, 3'b010};
    vecs[4]  = '{1'b0, 1'b1, 3'b000, 12'h030, 3'b010, p1, 12'h040, 3'b010, 3'b010};
    vecs[5]  = '{1'b0, 1'b0, 3'b000, 12'h030, 3'b010, p1, 12'h040, 3'b010, 3'b010};
    vecs[6]  = '{1'b0, 1'b1, 3'b000, 12'h030, 3'b010, p1, 12'h040, 3'b010, 3'b010};
    vecs[7]  = '{1'b0, 1'b1, 3'b000, 12'h030, 3'b010, p1, 12'h040, 3'b010, 3'b010};
    vecs[8]  = '{1'b0, 1'b1, 3'b000, 12'h030, 3'b010, p1, 12'h050, 3'b010, 3'b010};
    vecs[9]  = '{1'b0, 1'b1, 3'b000, 12'h030, 3'b010, p1, 12'h050, 3'b010, 3'b010};
    vecs[10] = '{1'b0, 1'b1, 3'b000, 12'h030, 3'b010, p1, 12'h050, 3'b010, 3'b010};
    vecs[11] = '{1'b0, 1'b1, 3'b000, 12'h030, 3'b010, p1, 12'h060, 3'b010, 3'b010};
    vecs[12] = '{1'b0, 1'b1, 3'b001, 12'h039, 3'b010, p1, 12'h069, 3'b010, 3'b011};
    vecs[13] = '{1'b0, 1'b1, 3'b000, 12'h030, 3'b010, p1, 12'h069, 3'b010, 3'b010};
    vecs[14] = '{1'b0, 1'b1, 3'b000, 12'h030, 3'b010, p1, 12'h079, 3'b010, 3'b010};
    vecs[15] = '{1'b1, 1'b1, 3'b100, 12'h030, 3'b010, p1, 12'h000, 3'b000, 3'b010};

    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      v = vecs[i];
      applyStimulus(v.r, v.t, v.st, v.iv, v.inc, v.per);
      checkEq($sformatf("vec%0d target_vol", i), 32'(target_vol), 32'(v.expVol));
      checkEq($sformatf("vec%0d env_active", i), 32'(env_active), 32'(v.expAct));
      checkEq($sformatf("vec%0d dac_enabled", i), 32'(dac_enabled), 32'(v.expDac));
    end

    // Decreasing ramp on channel 0 at period 1: reaches zero on tick 15, goes inactive on tick 16.
    applyStimulus(1'b0, 1'b0, 3'b001, 12'h00F, 3'b000, 9'b000_000_001);
    checkEq("ramp start vol", 32'(target_vol[3:0]), 32'd15);
    checkEq("ramp start active", 32'(env_active[0]), 32'd1);
    for (int k = 1; k <= 18; k++) begin
      applyStimulus(1'b0, 1'b1, 3'b000, 12'h00F, 3'b000, 9'b000_000_001);
      checkEq($sformatf("ramp tick%0d vol", k), 32'(target_vol[3:0]), 32'((k <= 15) ? 15 - k : 0));
      checkEq($sformatf("ramp tick%0d active", k), 32'(env_active[0]), 32'((k < 16) ? 1 : 0));
    end

    // Period 0 with a nonzero volume: frozen, inactive, DAC on; zero volume decaying: DAC off.
    applyStimulus(1'b0, 1'b0, 3'b100, 12'h900, 3'b000, 9'b000_000_000);
    for (int k = 0; k < 20; k++)
      applyStimulus(1'b0, 1'b1, 3'b000, 12'h900, 3'b000, 9'b000_000_000);
    checkEq("p0 vol", 32'(target_vol[11:8]), 32'd9);
    checkEq("p0 active", 32'(env_active[2]), 32'd0);
    checkEq("p0 dac", 32'(dac_enabled[2]), 32'd1);
    initial_volume = 12'h000; envelope_increasing = 3'b000;
    #1;
    checkEq("dac off", 32'(dac_enabled), 32'd0);

    // Randomized traffic, including period rewrites without a start and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      logic [NCH-1:0] st;
      for (int c = 0; c < NCH; c++) st[c] = ($urandom_range(0, 11) == 0);
      applyStimulus(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)), st,
                    NCH*VW'($urandom), NCH'($urandom), NCH*PW'($urandom));
    end

    // Reset in the middle of active ramps with a coincident start and tick.
    applyStimulus(1'b0, 1'b0, 3'b111, 12'h5A5, 3'b010, 9'b001_001_001);
    applyStimulus(1'b0, 1'b1, 3'b000, 12'h5A5, 3'b010, 9'b001_001_001);
    expV = 12'h4B4;
    checkEq("pre-reset vol", 32'(target_vol), 32'(expV));
    applyStimulus(1'b1, 1'b1, 3'b111, 12'h5A5, 3'b010, 9'b001_001_001);
    checkEq("mid reset vol", 32'(target_vol), 32'd0);
    checkEq("mid reset active", 32'(env_active), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/gb_envelope_bank.md
# gb_envelope_bank

Parametrised multi-channel volume envelope generator for the APU. It holds NUM_CH independent envelope units, one per channel, and all units share the frame-sequencer envelope tick. Each unit ramps its channel volume toward full scale or zero, one step per programmed number of ticks. It adds synchronous reset, a per-channel envelope-active flag that freezes the volume at its bound, and DAC-enable derivation. The block sits between the register file and the channel mixers, and replaces per-channel envelope instances.

## Interface
Parameters:
- NUM_CH, 3: number of envelope channels (GB: ch1, ch2, ch4).
- VOL_W, 4: volume width. Full scale is 2^VOL_W-1.
- PERIOD_W, 3: sweep-period field width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- clk_vol_env  in  1  envelope tick, a single-cycle pulse from the frame sequencer.
- start  in  NUM_CH  per-channel trigger, a single-cycle pulse.
- initial_volume  in  NUM_CH×VOL_W  packed; channel i occupies [i*VOL_W +: VOL_W].
- envelope_increasing  in  NUM_CH  direction: 1 = increment, 0 = decrement.
- num_envelope_sweeps  in  NUM_CH×PERIOD_W  packed; ticks per volume step; 0 = envelope off.
- target_vol  out  NUM_CH×VOL_W  current volume per channel, registered.
- env_active  out  NUM_CH  1 while the envelope is still stepping.
- dac_enabled  out  NUM_CH  combinational: (initial_volume != 0) or envelope_increasing.

## Operation
- Per-channel state: vol (VOL_W bits), timer (PERIOD_W bits), active (1 bit), period latch (PERIOD_W bits).
- Reset: vol=0, timer=0, active=0, period latch=0, for every channel.
- Start on channel i: vol <= initial_volume[i]; period latch and timer <= num_envelope_sweeps[i]; active <= (num_envelope_sweeps[i] != 0).
- Tick on a channel with active=1 and no start:
  - If timer > 1: timer decrements by 1.
  - If timer == 1: take a step and set timer <= period latch.
- Step, increasing direction:
  - vol < max: vol increments by 1.
  - vol == max: active <= 0 and vol is held.
- Step, decreasing direction:
  - vol > 0: vol decrements by 1.
  - vol == 0: active <= 0 and vol is held.
- Inactive channels ignore ticks. vol is held until the next start or reset.
- Direction and period inputs are sampled live at step time for direction. The period is taken from the latch captured at start. A register write without a start does not change the period.
- Channels are fully independent, with no cross-channel interaction.

## Timing
- Start asserted in cycle t: target_vol and env_active are valid at t+1.
- With period P ≠ 0, the first volume change is visible one cycle after the P-th tick following start. Later changes occur every P ticks.
- Start and tick in the same cycle: start wins and the tick is discarded for that channel.
- rst has priority over start and tick. Reset mid-ramp zeros all state at the next edge.
- Reaching the bound: the step that moves vol onto the bound keeps active=1. The next step finds vol at the bound, clears active and leaves vol unchanged.
- Arithmetic is unsigned VOL_W-bit. Wrap-around must never occur.
- dac_enabled has zero latency, because it is a pure function of the current inputs.

## Structure
- Package gb_apu_pkg holds:
  - constants ENV_NUM_CH, ENV_VOL_W, ENV_PERIOD_W;
  - a localparam-style function for full-scale volume.
- Sub-module gb_envelope_channel implements one unit (state, timer, step logic).
- The top level generates NUM_CH instances and does the bus packing and unpacking.

## Test plan
- Reset: assert rst with random state. Next cycle: all target_vol = 0 and all env_active = 0.
- Decreasing ramp: channel 0 start with vol=15, dir=0, P=1, then 16 ticks.
  - vol reads 14,13,…,0 after ticks 1–15.
  - env_active falls after tick 16.
  - vol stays 0.
- Increasing ramp with period: channel 1 start with vol=3, dir=1, P=3, then 9 ticks.
  - vol = 4 after tick 3, 5 after tick 6, 6 after tick 9.
  - vol unchanged on all other ticks.
- Period 0: start with vol=9, P=0, then 20 ticks.
  - vol stays 9 throughout.
  - env_active = 0.
  - dac_enabled = 1.
  - With vol=0 and dir=0: dac_enabled = 0.
- Collisions and independence:
  - Start on channel 2 coincident with a tick: vol = initial and timer reloads, with no step.
  - Channels 0 and 1 keep stepping undisturbed.
  - Changing num_envelope_sweeps mid-ramp without a start leaves the step spacing unchanged.
- Reset mid-operation: rst asserted during an active ramp with a coincident start. The next cycle shows the reset values.
